// File: rtl/wallace_cpa_stage.sv
// Final carry-propagate adder of the Wallace-tree multiplier: adds the aligned
// sum/carry vectors CHUNK bits per cycle and hands off the product via valid/ready.
module wallace_cpa_stage #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] sum_vec,
    input  logic [WIDTH-1:0] carry_vec,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy
);

    localparam int NCH = WIDTH / CHUNK;
    localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0)) begin : g_bad_params
        $error("wallace_cpa_stage: WIDTH must be a positive multiple of CHUNK");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One chunk of the ripple: {carry_out, sum} of two CHUNK-bit slices plus carry-in.
    function automatic logic [CHUNK:0] chunk_add(
        input logic [CHUNK-1:0] a,
        input logic [CHUNK-1:0] b,
        input logic             ci
    );
        return {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [WIDTH-1:0]  sum_op_r;
    logic [WIDTH-1:0]  carry_op_r;
    logic [WIDTH-1:0]  result_r;
    logic [WIDTH-1:0]  result_nxt_s;
    logic [CW-1:0]     cnt_r;
    logic              carry_r;
    logic              cout_r;
    logic              out_valid_r;
    logic              in_ready_r;
    logic              busy_r;
    logic              in_ready_nxt_s;
    logic              busy_nxt_s;
    logic [CHUNK-1:0]  sum_chunk_s;
    logic [CHUNK-1:0]  carry_chunk_s;
    logic [CHUNK:0]    add_s;
    logic              last_chunk_s;
    logic              accept_s;
    logic              release_s;

    // Handshake qualifiers and chunk-position decode.
    always_comb begin
        accept_s     = in_valid & in_ready_r & (state_r == ST_IDLE);
        release_s    = out_valid_r & out_ready & (state_r == ST_DONE);
        last_chunk_s = (cnt_r == CW'(NCH - 1));
    end

    // Select the operand slices addressed by the chunk counter and add them.
    always_comb begin
        sum_chunk_s   = {CHUNK{1'b0}};
        carry_chunk_s = {CHUNK{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            if (cnt_r == CW'(i)) begin
                sum_chunk_s   = sum_op_r[i*CHUNK +: CHUNK];
                carry_chunk_s = carry_op_r[i*CHUNK +: CHUNK];
            end else begin
                sum_chunk_s   = sum_chunk_s;
                carry_chunk_s = carry_chunk_s;
            end
        end
        add_s = chunk_add(sum_chunk_s, carry_chunk_s, carry_r);
    end

    // Merge the freshly added chunk into the result; other chunks keep their value.
    always_comb begin
        result_nxt_s = result_r;
        for (int i = 0; i < NCH; i++) begin
            if ((state_r == ST_ADD) && (cnt_r == CW'(i))) begin
                result_nxt_s[i*CHUNK +: CHUNK] = add_s[CHUNK-1:0];
            end else begin
                result_nxt_s[i*CHUNK +: CHUNK] = result_r[i*CHUNK +: CHUNK];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ST_ADD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ADD: begin
                if (last_chunk_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_ADD;
                end
            end
            ST_DONE: begin
                if (release_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Next values of the state-derived outputs; registered below.
    always_comb begin
        in_ready_nxt_s = (state_nxt_s == ST_IDLE);
        busy_nxt_s     = (state_nxt_s != ST_IDLE);
    end

    // Operand capture at acceptance; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum_op_r   <= {WIDTH{1'b0}};
            carry_op_r <= {WIDTH{1'b0}};
        end else if (accept_s) begin
            sum_op_r   <= sum_vec;
            carry_op_r <= carry_vec;
        end
    end

    // Chunk counter and the inter-chunk carry; the top carry never wraps to chunk 0.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r   <= {CW{1'b0}};
            carry_r <= 1'b0;
        end else if (accept_s) begin
            cnt_r   <= {CW{1'b0}};
            carry_r <= 1'b0;
        end else if (state_r == ST_ADD) begin
            cnt_r   <= last_chunk_s ? {CW{1'b0}} : (cnt_r + CW'(1));
            carry_r <= last_chunk_s ? 1'b0 : add_s[CHUNK];
        end
    end

    // Result and carry-out registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            result_r <= {WIDTH{1'b0}};
            cout_r   <= 1'b0;
        end else begin
            result_r <= result_nxt_s;
            if ((state_r == ST_ADD) && last_chunk_s) begin
                cout_r <= add_s[CHUNK];
            end
        end
    end

    // out_valid rises one cycle after DONE is entered and drops on the handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
        end else if (release_s) begin
            out_valid_r <= 1'b0;
        end else if (state_r == ST_DONE) begin
            out_valid_r <= 1'b1;
        end
    end

    // Registered handshake/status outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            in_ready_r <= 1'b1;
            busy_r     <= 1'b0;
        end else begin
            in_ready_r <= in_ready_nxt_s;
            busy_r     <= busy_nxt_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign cout      = cout_r;
    assign busy      = busy_r;

endmodule
